// File: rtl/alu_share_arbiter.sv
// Two-port valid/ready arbiter sharing one ALU; holds the winner's op for ALU_LAT cycles,
// then returns result/zero to the winner. Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_aluop,
  input  logic [5:0]       req0_func,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_aluop,
  input  logic [5:0]       req1_func,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [2:0]       alu_aluop,
  output logic [5:0]       alu_func,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_chk
    $error("ALU_LAT must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  typedef struct packed {
    logic [2:0]       aluop;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           r_state, w_state_nxt;
  req_t             w_req [2];
  req_t             r_op;
  logic             r_owner;
  logic [3:0]       r_busy_cnt;
  logic [WIDTH-1:0] r_resp_result;
  logic             r_resp_zero;
  logic             w_grant, w_winner, w_owner_rdy;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             r_last_grant;
`endif

  assign w_req[0]    = {req0_aluop, req0_func, req0_a, req0_b};
  assign w_req[1]    = {req1_aluop, req1_func, req1_a, req1_b};
  assign w_owner_rdy = r_owner ? resp1_ready : resp0_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_winner    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req0_valid && req1_valid) begin
          w_grant = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
          w_winner = 1'b0;
`else
          w_winner = ~r_last_grant;
`endif
        end else if (req0_valid || req1_valid) begin
          w_grant  = 1'b1;
          w_winner = req1_valid;
        end
        if (w_grant) w_state_nxt = S_BUSY;
      end
      S_BUSY:  if (r_busy_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:  if (w_owner_rdy) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // grant is only ever raised in IDLE, so ready is naturally gated by state
  assign req0_ready  = w_grant && !w_winner;
  assign req1_ready  = w_grant &&  w_winner;
  assign resp0_valid = (r_state == S_RESP) && !r_owner;
  assign resp1_valid = (r_state == S_RESP) &&  r_owner;
  assign resp_result = r_resp_result;
  assign resp_zero   = r_resp_zero;
  assign alu_aluop   = r_op.aluop;
  assign alu_func    = r_op.func;
  assign alu_a       = r_op.a;
  assign alu_b       = r_op.b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_busy_cnt    <= 4'd0;
      r_op          <= '0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_last_grant  <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_op       <= w_req[w_winner];
        r_owner    <= w_winner;
        r_busy_cnt <= 4'(ALU_LAT - 1);
`ifndef ALU_ARB_FIXED_PRIO_EN
        r_last_grant <= w_winner;
`endif
      end
      if (r_state == S_BUSY) begin
        if (r_busy_cnt == 4'd0) begin
          r_resp_result <= alu_result;
          r_resp_zero   <= alu_zero;
        end else begin
          r_busy_cnt <= r_busy_cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, corner sequences,
// and a random run against a cycle-level reference model (ALU_LAT=1 and ALU_LAT=3 instances).
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  function automatic logic [31:0] alu_f(logic [2:0] op, logic [5:0] fn, logic [31:0] a, logic [31:0] b);
    if (op == 3'd0) begin
      case (fn)
        6'd32:   return a + b;
        6'd34:   return a - b;
        6'd36:   return a & b;
        6'd37:   return a | b;
        6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: return 32'd0;
      endcase
    end else if (op == 3'd1) return a - b;
    return a + b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- DUT with ALU_LAT=1 ----------------
  logic        rq_v [2], rq_r [2], rs_v [2], rs_r [2];
  logic [2:0]  rq_op [2];
  logic [5:0]  rq_fn [2];
  logic [31:0] rq_a [2], rq_b [2];
  logic [31:0] res, aa, ab, ares;
  logic        zr, azr;
  logic [2:0]  aop;
  logic [5:0]  afn;

  assign ares = alu_f(aop, afn, aa, ab);
  assign azr  = (ares == 32'd0);

  alu_share_arbiter #(.WIDTH(32), .ALU_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(rq_v[0]), .req0_ready(rq_r[0]), .req0_aluop(rq_op[0]), .req0_func(rq_fn[0]),
    .req0_a(rq_a[0]), .req0_b(rq_b[0]),
    .req1_valid(rq_v[1]), .req1_ready(rq_r[1]), .req1_aluop(rq_op[1]), .req1_func(rq_fn[1]),
    .req1_a(rq_a[1]), .req1_b(rq_b[1]),
    .resp0_valid(rs_v[0]), .resp0_ready(rs_r[0]), .resp1_valid(rs_v[1]), .resp1_ready(rs_r[1]),
    .resp_result(res), .resp_zero(zr),
    .alu_aluop(aop), .alu_func(afn), .alu_a(aa), .alu_b(ab),
    .alu_result(ares), .alu_zero(azr)
  );

  // ---------------- DUT with ALU_LAT=3 ----------------
  logic        t3_v0, t3_r0, t3_r1, t3_sv0, t3_sv1, t3_z, t3_az;
  logic [2:0]  t3_op, t3_aop;
  logic [5:0]  t3_fn, t3_afn;
  logic [31:0] t3_a, t3_b, t3_res, t3_aa, t3_ab, t3_ares;

  assign t3_ares = alu_f(t3_aop, t3_afn, t3_aa, t3_ab);
  assign t3_az   = (t3_ares == 32'd0);

  alu_share_arbiter #(.WIDTH(32), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(t3_v0), .req0_ready(t3_r0), .req0_aluop(t3_op), .req0_func(t3_fn),
    .req0_a(t3_a), .req0_b(t3_b),
    .req1_valid(1'b0), .req1_ready(t3_r1), .req1_aluop(3'd0), .req1_func(6'd0),
    .req1_a(32'd0), .req1_b(32'd0),
    .resp0_valid(t3_sv0), .resp0_ready(1'b1), .resp1_valid(t3_sv1), .resp1_ready(1'b1),
    .resp_result(t3_res), .resp_zero(t3_z),
    .alu_aluop(t3_aop), .alu_func(t3_afn), .alu_a(t3_aa), .alu_b(t3_ab),
    .alu_result(t3_ares), .alu_zero(t3_az)
  );

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy0"}, rq_r[0], 0);  chk({tag, "_rdy1"}, rq_r[1], 0);
    chk({tag, "_rsv0"}, rs_v[0], 0);  chk({tag, "_rsv1"}, rs_v[1], 0);
    chk({tag, "_res"}, res, 0);       chk({tag, "_zero"}, zr, 0);
    chk({tag, "_aop"}, aop, 0);       chk({tag, "_afn"}, afn, 0);
    chk({tag, "_aa"}, aa, 0);         chk({tag, "_ab"}, ab, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rq_v[0] = 0; rq_v[1] = 0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Issue one op on port p, expect grant, ALU_LAT latency and the given result.
  task automatic run_op(input int p, input op_t o, input logic [31:0] er, input logic ez);
    int k;
    @(negedge clk);
    rq_v[p] = 1; rq_op[p] = o.op; rq_fn[p] = o.fn; rq_a[p] = o.a; rq_b[p] = o.b;
    rs_r[0] = 1; rs_r[1] = 1;
    #1;
    chk("op_grant", rq_r[p], 1);
    chk("op_nogrant", rq_r[1-p], 0);
    @(posedge clk); #1 rq_v[p] = 0;
    k = 0;
    while (!rs_v[p] && k < 20) begin
      chk("op_other_idle", rs_v[1-p], 0);
      @(posedge clk); #1 k++;
    end
    chk("op_latency", k, 1);
    chk("op_other_resp", rs_v[1-p], 0);
    chk("op_result", res, er);
    chk("op_zero", zr, ez);
    @(posedge clk); #1;
    chk("op_done", rs_v[p], 0);
  endtask

  typedef struct {
    int          port;
    op_t         o;
    logic [31:0] er;
    logic        ez;
  } vec_t;

  vec_t vecs [8];
  logic [5:0] fns [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int g [4];
    int t [4];
    int n, cyc, k;
    // reference model state
    op_t  pend [2];
    logic pv [2];
    op_t  cur;
    int   m_phase, m_rem, m_owner, m_last, win, e_r0, e_r1;

    fns[0] = 6'd32; fns[1] = 6'd34; fns[2] = 6'd36; fns[3] = 6'd37; fns[4] = 6'd42;
    vecs[0] = '{0, '{3'd0, 6'd32, 32'd5, 32'd7}, 32'd12, 1'b0};
    vecs[1] = '{1, '{3'd0, 6'd34, 32'd9, 32'd9}, 32'd0, 1'b1};
    vecs[2] = '{0, '{3'd0, 6'd36, 32'hF0, 32'h3C}, 32'h30, 1'b0};
    vecs[3] = '{1, '{3'd0, 6'd37, 32'hF0, 32'h0F}, 32'hFF, 1'b0};
    vecs[4] = '{0, '{3'd0, 6'd42, 32'hFFFF_FFFF, 32'd1}, 32'd1, 1'b0};
    vecs[5] = '{1, '{3'd0, 6'd42, 32'd1, 32'hFFFF_FFFF}, 32'd0, 1'b1};
    vecs[6] = '{0, '{3'd1, 6'd0, 32'd3, 32'd3}, 32'd0, 1'b1};
    vecs[7] = '{1, '{3'd2, 6'd0, 32'hFFFF_FFFF, 32'd1}, 32'd0, 1'b1};

    for (int i = 0; i < 2; i++) begin
      rq_v[i] = 0; rq_op[i] = 0; rq_fn[i] = 0; rq_a[i] = 0; rq_b[i] = 0; rs_r[i] = 1;
    end
    t3_v0 = 0; t3_op = 0; t3_fn = 0; t3_a = 0; t3_b = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_reset_vals("rst");

    // ALU_LAT=3: slt held 3 cycles, result 3 edges after accept
    @(negedge clk);
    t3_v0 = 1; t3_op = 3'd0; t3_fn = 6'd42; t3_a = 32'hFFFF_FFFF; t3_b = 32'd1;
    #1 chk("lat3_grant", t3_r0, 1);
    @(posedge clk); #1 t3_v0 = 0;
    k = 0;
    while (!t3_sv0 && k < 20) begin
      chk("lat3_a", t3_aa, 32'hFFFF_FFFF);
      chk("lat3_b", t3_ab, 32'd1);
      chk("lat3_fn", t3_afn, 6'd42);
      @(posedge clk); #1 k++;
    end
    chk("lat3_latency", k, 3);
    chk("lat3_result", t3_res, 1);
    chk("lat3_resp1", t3_sv1, 0);

    // directed vector table
    for (int i = 0; i < 8; i++) run_op(vecs[i].port, vecs[i].o, vecs[i].er, vecs[i].ez);

    // both valid every cycle: grant order and issue interval
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rq_op[i] = 3'd0; rq_fn[i] = 6'd32; rq_a[i] = i; rq_b[i] = 32'd1; rs_r[i] = 1;
    end
    rq_v[0] = 1; rq_v[1] = 1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk); #1;
      if (rq_r[0] || rq_r[1]) begin
        chk("tie_onehot", rq_r[0] & rq_r[1], 0);
        g[n] = rq_r[1] ? 1 : 0; t[n] = cyc; n++;
      end
      cyc++;
    end
    chk("tie_count", n, 4);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("tie_g0", g[0], 0); chk("tie_g1", g[1], 0); chk("tie_g2", g[2], 0); chk("tie_g3", g[3], 0);
`else
    chk("tie_g0", g[0], 0); chk("tie_g1", g[1], 1); chk("tie_g2", g[2], 0); chk("tie_g3", g[3], 1);
`endif
    chk("tie_interval", t[1] - t[0], 3);
    rq_v[0] = 0; rq_v[1] = 0;

    // response backpressure on port 0, port 1 waits
    do_reset();
    @(negedge clk);
    rq_v[0] = 1; rq_op[0] = 0; rq_fn[0] = 6'd32; rq_a[0] = 5; rq_b[0] = 7;
    rs_r[0] = 0; rs_r[1] = 1;
    @(posedge clk); #1 rq_v[0] = 0;
    k = 0;
    while (!rs_v[0] && k < 20) begin @(posedge clk); #1 k++; end
    rq_v[1] = 1; rq_op[1] = 0; rq_fn[1] = 6'd34; rq_a[1] = 9; rq_b[1] = 9;
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_valid", rs_v[0], 1);
      chk("bp_result", res, 12);
      chk("bp_rdy1", rq_r[1], 0);
    end
    @(negedge clk); rs_r[0] = 1;
    #1 chk("bp_rdy1_at_done", rq_r[1], 0);
    @(posedge clk); #1;
    chk("bp_rdy1_next", rq_r[1], 1);
    @(posedge clk); #1 rq_v[1] = 0;
    k = 0;
    while (!rs_v[1] && k < 20) begin @(posedge clk); #1 k++; end
    chk("bp_r1_valid", rs_v[1], 1);
    chk("bp_r1_result", res, 0);
    chk("bp_r1_zero", zr, 1);
    chk("bp_r1_rsv0", rs_v[0], 0);
    @(posedge clk);

    // reset while BUSY aborts the op
    @(negedge clk);
    rq_v[0] = 1; rq_op[0] = 0; rq_fn[0] = 6'd32; rq_a[0] = 5; rq_b[0] = 7;
    @(posedge clk); #1 rq_v[0] = 0; reset = 1;
    @(posedge clk); #1 reset = 0;
    chk_reset_vals("abort");
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_rsv0", rs_v[0], 0); chk("abort_rsv1", rs_v[1], 0);
    end
    run_op(0, '{3'd0, 6'd32, 32'd5, 32'd7}, 32'd12, 1'b0);

    // randomized run against the reference model
    do_reset();
    pv[0] = 0; pv[1] = 0;
    cur = '{3'd0, 6'd0, 32'd0, 32'd0};
    m_phase = 0; m_rem = 0; m_owner = 0; m_last = 1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (pv[p] && $urandom_range(0, 15) == 0) pv[p] = 0;
        else if (!pv[p] && $urandom_range(0, 2) == 0) begin
          pv[p] = 1;
          pend[p].op = 3'($urandom_range(0, 2));
          pend[p].fn = fns[$urandom_range(0, 4)];
          pend[p].a  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
          pend[p].b  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
        end
        rq_v[p] = pv[p];
        if (pv[p]) begin
          rq_op[p] = pend[p].op; rq_fn[p] = pend[p].fn; rq_a[p] = pend[p].a; rq_b[p] = pend[p].b;
        end
        rs_r[p] = 1'($urandom_range(0, 1));
      end
      #1;
      win = -1;
      if (m_phase == 0) begin
        if (pv[0] && pv[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          win = 0;
`else
          win = 1 - m_last;
`endif
        end else if (pv[0]) win = 0;
        else if (pv[1]) win = 1;
      end
      e_r0 = (win == 0) ? 1 : 0;
      e_r1 = (win == 1) ? 1 : 0;
      chk("rnd_rdy0", rq_r[0], e_r0);
      chk("rnd_rdy1", rq_r[1], e_r1);
      chk("rnd_rsv0", rs_v[0], (m_phase == 2 && m_owner == 0) ? 1 : 0);
      chk("rnd_rsv1", rs_v[1], (m_phase == 2 && m_owner == 1) ? 1 : 0);
      chk("rnd_alu_a", aa, cur.a);
      chk("rnd_alu_fn", afn, cur.fn);
      if (m_phase == 2) begin
        chk("rnd_result", res, alu_f(cur.op, cur.fn, cur.a, cur.b));
        chk("rnd_zero", zr, alu_f(cur.op, cur.fn, cur.a, cur.b) == 32'd0);
      end
      // advance the model across the coming edge
      if (win >= 0) begin
        cur = pend[win]; m_owner = win; m_last = win; m_rem = 1; m_phase = 1; pv[win] = 0;
      end else if (m_phase == 1) begin
        m_rem--;
        if (m_rem == 0) m_phase = 2;
      end else if (m_phase == 2 && rs_r[m_owner]) m_phase = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
